// File: rtl/drink_pkg.sv
// Shared types and constants for the drink order front-end.
// Price lookup is used only when PRICE_CHECK_EN is defined.
package drink_pkg;

    localparam int PAY_W_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_ISSUE,
        ST_REFUND
    } state_e;

    localparam logic [7:0] DRINK_C1 = 8'hC1;
    localparam logic [7:0] DRINK_C2 = 8'hC2;
    localparam logic [7:0] DRINK_C3 = 8'hC3;
    localparam logic [7:0] DRINK_B6 = 8'hB6;
    localparam logic [7:0] DRINK_B7 = 8'hB7;
    localparam logic [7:0] DRINK_D4 = 8'hD4;
    localparam logic [7:0] DRINK_D5 = 8'hD5;

    // Price in coin units; 0 marks an unknown code.
    function automatic logic [4:0] price_of(input logic [7:0] code);
        logic [4:0] p;
        case (code)
            DRINK_C1, DRINK_C2, DRINK_C3: p = 5'd6;
            DRINK_B6, DRINK_B7:           p = 5'd8;
            DRINK_D4, DRINK_D5:           p = 5'd10;
            default:                      p = 5'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/therm_enc.sv
// Count to thermometer code: count n sets the n LSBs.
// Purely combinational.
module therm_enc #(
    parameter int W  = 10,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [CW-1:0] count_i,
    output logic [W-1:0]  therm_o
);

    // Bit i is set when i is below the count.
    always_comb begin
        therm_o = '0;
        for (int i = 0; i < W; i++) begin
            therm_o[i] = (i < int'(count_i));
        end
    end

endmodule

// File: rtl/drink_order_collector.sv
// Coin collection, selection latch and order/refund issue.
// Optional price check enabled by defining PRICE_CHECK_EN.
module drink_order_collector
    import drink_pkg::*;
#(
    parameter int PAY_W   = PAY_W_DEF,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       coin,
    output logic             coin_ready,
    input  logic             sel_valid,
    input  logic [7:0]       sel_code,
    input  logic             cancel,
    output logic             valid,
    output logic [PAY_W-1:0] pay_in,
    output logic [7:0]       code,
    output logic             refund_valid,
    output logic [3:0]       refund_units,
    output logic             sel_reject
);

    localparam int UW = $clog2(PAY_W + 1);
    localparam int SW = UW + 2;
    localparam int TW = $clog2(TIMEOUT);

    state_e           state_q;
    logic [UW-1:0]    units_q;
    logic [3:0]       ovf_q;
    logic [3:0]       change_q;
    logic [TW-1:0]    timer_q;
    logic             coin_ready_q;
    logic             valid_q;
    logic [PAY_W-1:0] pay_q;
    logic [7:0]       code_q;
    logic             refund_valid_q;
    logic [3:0]       refund_q;

    logic [SW-1:0]    sum;
    logic [SW-1:0]    excess;
    logic [SW-1:0]    ovf_wide;
    logic [SW-1:0]    cash_wide;
    logic [SW-1:0]    change_wide;
    logic [UW-1:0]    units_d;
    logic [3:0]       ovf_d;
    logic [3:0]       cash_d;
    logic [3:0]       change_d;
    logic [UW-1:0]    pay_cnt;
    logic             accept;
    logic [PAY_W-1:0] therm;

    // Coin accumulation with saturation into the overflow counter.
    always_comb begin
        sum    = SW'(units_q) + SW'(coin);
        units_d = sum[UW-1:0];
        excess = '0;
        if (sum > SW'(PAY_W)) begin
            units_d = UW'(PAY_W);
            excess  = sum - SW'(PAY_W);
        end
        ovf_wide  = SW'(ovf_q) + excess;
        ovf_d     = (ovf_wide > SW'(15)) ? 4'd15 : ovf_wide[3:0];
        cash_wide = SW'(units_d) + SW'(ovf_d);
        cash_d    = (cash_wide > SW'(15)) ? 4'd15 : cash_wide[3:0];
    end

`ifdef PRICE_CHECK_EN
    logic [4:0] price;
    logic       sel_reject_q;

    // Selection is accepted only for a known drink that is fully paid.
    always_comb begin
        price       = price_of(sel_code);
        accept      = (price != 5'd0) && (SW'(price) <= SW'(units_d));
        pay_cnt     = accept ? UW'(price) : units_d;
        change_wide = SW'(units_d) - SW'(price) + SW'(ovf_d);
        change_d    = (change_wide > SW'(15)) ? 4'd15
                                              : change_wide[3:0];
    end

    assign sel_reject = sel_reject_q;
`else
    // Any code is issued; only overflow units come back as change.
    always_comb begin
        accept      = 1'b1;
        pay_cnt     = units_d;
        change_wide = '0;
        change_d    = ovf_d;
    end

    assign sel_reject = 1'b0;
`endif

    therm_enc #(
        .W  (PAY_W),
        .CW (UW)
    ) u_therm (
        .count_i (pay_cnt),
        .therm_o (therm)
    );

    // Main FSM; every output is registered on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            units_q        <= '0;
            ovf_q          <= '0;
            change_q       <= '0;
            timer_q        <= '0;
            coin_ready_q   <= 1'b1;
            valid_q        <= 1'b0;
            pay_q          <= '0;
            code_q         <= '0;
            refund_valid_q <= 1'b0;
            refund_q       <= '0;
`ifdef PRICE_CHECK_EN
            sel_reject_q   <= 1'b0;
`endif
        end else begin
            valid_q        <= 1'b0;
            pay_q          <= '0;
            code_q         <= '0;
            refund_valid_q <= 1'b0;
            refund_q       <= '0;
`ifdef PRICE_CHECK_EN
            sel_reject_q   <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (coin != 2'd0) begin
                        units_q <= units_d;
                        ovf_q   <= ovf_d;
                        timer_q <= '0;
                        state_q <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    units_q <= units_d;
                    ovf_q   <= ovf_d;
                    if (cancel) begin
                        refund_valid_q <= 1'b1;
                        refund_q       <= cash_d;
                        coin_ready_q   <= 1'b0;
                        state_q        <= ST_REFUND;
                    end else if (sel_valid) begin
                        if (accept) begin
                            valid_q      <= 1'b1;
                            pay_q        <= therm;
                            code_q       <= sel_code;
                            change_q     <= change_d;
                            coin_ready_q <= 1'b0;
                            state_q      <= ST_ISSUE;
                        end
`ifdef PRICE_CHECK_EN
                        else begin
                            sel_reject_q <= 1'b1;
                            timer_q      <= '0;
                        end
`endif
                    end else if (coin != 2'd0) begin
                        timer_q <= '0;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        refund_valid_q <= 1'b1;
                        refund_q       <= cash_d;
                        coin_ready_q   <= 1'b0;
                        state_q        <= ST_REFUND;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    units_q <= '0;
                    ovf_q   <= '0;
                    if (change_q != 4'd0) begin
                        refund_valid_q <= 1'b1;
                        refund_q       <= change_q;
                        state_q        <= ST_REFUND;
                    end else begin
                        coin_ready_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    units_q      <= '0;
                    ovf_q        <= '0;
                    coin_ready_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign coin_ready   = coin_ready_q;
    assign valid        = valid_q;
    assign pay_in       = pay_q;
    assign code         = code_q;
    assign refund_valid = refund_valid_q;
    assign refund_units = refund_q;

endmodule

// File: tb/tb_drink_order_collector.sv
// Bench for drink_order_collector: directed cases plus random traffic.
// Price checks are exercised when PRICE_CHECK_EN is defined.
module tb_drink_order_collector;

    localparam int PW  = 10;
    localparam int TMO = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    coin;
    logic          coin_ready;
    logic          sel_valid;
    logic [7:0]    sel_code;
    logic          cancel;
    logic          valid;
    logic [PW-1:0] pay_in;
    logic [7:0]    code;
    logic          refund_valid;
    logic [3:0]    refund_units;
    logic          sel_reject;

    drink_order_collector #(
        .PAY_W   (PW),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin         (coin),
        .coin_ready   (coin_ready),
        .sel_valid    (sel_valid),
        .sel_code     (sel_code),
        .cancel       (cancel),
        .valid        (valid),
        .pay_in       (pay_in),
        .code         (code),
        .refund_valid (refund_valid),
        .refund_units (refund_units),
        .sel_reject   (sel_reject)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: session phase and coin bookkeeping in plain ints.
    int m_ph;
    int m_units;
    int m_ovf;
    int m_idle;
    int m_chg;
    int e_valid, e_pay, e_code, e_rv, e_ru, e_rej, e_cr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

`ifdef PRICE_CHECK_EN
    function automatic int m_price(input int c);
        case (c)
            'hC1, 'hC2, 'hC3: return 6;
            'hB6, 'hB7:       return 8;
            'hD4, 'hD5:       return 10;
            default:          return 0;
        endcase
    endfunction
`endif

    task automatic model_reset();
        m_ph = 0; m_units = 0; m_ovf = 0; m_idle = 0; m_chg = 0;
        e_valid = 0; e_pay = 0; e_code = 0;
        e_rv = 0; e_ru = 0; e_rej = 0; e_cr = 1;
    endtask

    // Predict outputs visible after the next clock edge.
    task automatic model_step(input int c, input int sv,
                              input int sc, input int cn);
        int tot, paid, chg, ok;
        e_valid = 0; e_pay = 0; e_code = 0;
        e_rv = 0; e_ru = 0; e_rej = 0;
        case (m_ph)
            0: begin
                if (c != 0) begin
                    m_units = c; m_ovf = 0; m_idle = 0; m_ph = 1;
                end
            end
            1: begin
                tot     = m_units + c;
                m_units = (tot > PW) ? PW : tot;
                m_ovf   = sat15(m_ovf + ((tot > PW) ? tot - PW : 0));
                if (cn != 0) begin
                    e_rv = 1; e_ru = sat15(m_units + m_ovf); m_ph = 3;
                end else if (sv != 0) begin
`ifdef PRICE_CHECK_EN
                    paid = m_price(sc);
                    ok   = (paid != 0 && paid <= m_units) ? 1 : 0;
                    chg  = sat15(m_units - paid + m_ovf);
`else
                    paid = m_units;
                    ok   = 1;
                    chg  = m_ovf;
`endif
                    if (ok != 0) begin
                        e_valid = 1;
                        e_pay   = (1 << paid) - 1;
                        e_code  = sc;
                        m_chg   = chg;
                        m_ph    = 2;
                    end else begin
                        e_rej  = 1;
                        m_idle = 0;
                    end
                end else if (c != 0) begin
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        e_rv = 1; e_ru = sat15(m_units + m_ovf); m_ph = 3;
                    end
                end
            end
            2: begin
                if (m_chg > 0) begin
                    e_rv = 1; e_ru = m_chg; m_ph = 3;
                end else begin
                    m_ph = 0;
                end
                m_units = 0; m_ovf = 0;
            end
            default: begin
                m_ph = 0; m_units = 0; m_ovf = 0;
            end
        endcase
        e_cr = (m_ph <= 1) ? 1 : 0;
    endtask

    task automatic compare_all();
        chk("valid",        32'(valid),        32'(e_valid));
        chk("pay_in",       32'(pay_in),       32'(e_pay));
        chk("code",         32'(code),         32'(e_code));
        chk("refund_valid", 32'(refund_valid), 32'(e_rv));
        chk("refund_units", 32'(refund_units), 32'(e_ru));
        chk("sel_reject",   32'(sel_reject),   32'(e_rej));
        chk("coin_ready",   32'(coin_ready),   32'(e_cr));
    endtask

    task automatic step(input int c, input int sv,
                        input int sc, input int cn);
        coin      = 2'(c);
        sel_valid = (sv != 0);
        sel_code  = 8'(sc);
        cancel    = (cn != 0);
        model_step(c, sv, sc, cn);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; coin = '0; sel_valid = 1'b0;
        sel_code = '0; cancel = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        compare_all();
    endtask

    int codes [8] = '{'hC1, 'hC2, 'hC3, 'hB6, 'hB7, 'hD4, 'hD5, 'h5A};

    initial begin
        do_reset();

        // 1: 6 units, C1 issued, nothing returned.
        step(3, 0, 0, 0);
        step(3, 0, 0, 0);
        step(0, 1, 'hC1, 0);
        chk("t1_valid", 32'(valid), 32'd1);
        chk("t1_pay",   32'(pay_in), 32'h03F);
        chk("t1_code",  32'(code), 32'hC1);
        step(0, 0, 0, 0);
        chk("t1_pay_idle", 32'(pay_in), 32'd0);
        chk("t1_no_refund", 32'(refund_valid), 32'd0);

        // 2: 12 units, D4 issued, overflow refunded.
        for (int i = 0; i < 4; i++) step(3, 0, 0, 0);
        step(0, 1, 'hD4, 0);
        chk("t2_pay",  32'(pay_in), 32'h3FF);
        chk("t2_code", 32'(code), 32'hD4);
        step(0, 0, 0, 0);
        chk("t2_rv", 32'(refund_valid), 32'd1);
        chk("t2_ru", 32'(refund_units), 32'd2);
        step(0, 0, 0, 0);

        // 3: cancel refunds; cancel beats a same-cycle selection.
        step(0, 1, 'hC1, 1);
        step(2, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("t3_rv", 32'(refund_valid), 32'd1);
        chk("t3_ru", 32'(refund_units), 32'd2);
        step(0, 0, 0, 0);
        step(2, 0, 0, 0);
        step(0, 1, 'hC2, 1);
        chk("t3b_valid", 32'(valid), 32'd0);
        chk("t3b_rv",    32'(refund_valid), 32'd1);
        step(0, 0, 0, 0);

        // 4: inactivity timeout.
        step(1, 0, 0, 0);
        for (int i = 0; i < TMO - 1; i++) step(0, 0, 0, 0);
        chk("t4_pre", 32'(refund_valid), 32'd0);
        step(0, 0, 0, 0);
        chk("t4_rv", 32'(refund_valid), 32'd1);
        chk("t4_ru", 32'(refund_units), 32'd1);
        step(0, 0, 0, 0);
        chk("t4_ready", 32'(coin_ready), 32'd1);

`ifdef PRICE_CHECK_EN
        // 5: underpaid selection rejected, then completed.
        step(3, 0, 0, 0);
        step(3, 0, 0, 0);
        step(0, 1, 'hD5, 0);
        chk("t5_rej",   32'(sel_reject), 32'd1);
        chk("t5_valid", 32'(valid), 32'd0);
        step(3, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 'hD5, 0);
        chk("t5_pay", 32'(pay_in), 32'h3FF);
        step(0, 0, 0, 0);

        // 6: change returned after a cheaper drink.
        for (int i = 0; i < 3; i++) step(3, 0, 0, 0);
        step(0, 1, 'hB6, 0);
        chk("t6_pay", 32'(pay_in), 32'h0FF);
        step(0, 0, 0, 0);
        chk("t6_ru", 32'(refund_units), 32'd1);
        step(0, 0, 0, 0);
`endif

        // Reset in the middle of an order discards the coins.
        step(3, 0, 0, 0);
        step(2, 0, 0, 0);
        do_reset();
        chk("rst_ready", 32'(coin_ready), 32'd1);
        for (int i = 0; i < TMO + 2; i++) step(0, 0, 0, 0);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                int c, sv, sc, cn;
                c  = ($urandom_range(0, 3) == 0) ?
                     int'($urandom_range(1, 3)) : 0;
                sv = ($urandom_range(0, 11) == 0) ? 1 : 0;
                sc = codes[$urandom_range(0, 7)];
                cn = ($urandom_range(0, 39) == 0) ? 1 : 0;
                if ($urandom_range(0, 9) == 0) c = 0;
                step(c, sv, sc, cn);
                // Occasional quiet stretch to reach the timeout.
                if ($urandom_range(0, 99) == 0) begin
                    for (int q = 0; q < TMO + 1; q++) step(0, 0, 0, 0);
                end
            end
        end

        coin = '0; sel_valid = 1'b0; cancel = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
